dm_bank: RTL and testbench

Byte-enabled data memory bank for the pipelined MIPS core. It sits directly downstream of the M-stage memory-interface logic and consumes its `m_data_addr`, `m_data_wdata` and `m_data_byteen` outputs. Loads return data one cycle later, aligned with the W stage, already sign- or zero-extended per the load type. After reset, a sweep state machine zero-clears the array before any request is accepted.

---
 rtl/dm_pkg.sv | 29 ++
 rtl/dm_load_ext.sv | 29 ++
 rtl/dm_bank.sv | 111 +++++++++++
 tb/tb_dm_bank.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_bank shared types: load-op codes, sweep FSM states, default depth.
// Optional DM_ALIGN_CHECK_EN build uses be_legal() for store lane checks.
package dm_pkg;

  localparam int DM_DEPTH_DEFAULT = 3072;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dm_state_e;

  // Legal store lanes: one byte anywhere, a half on an even
  // offset, or a full word at offset 0.
  function automatic logic be_legal(
    input logic [3:0] be,
    input logic [1:0] a
  );
    return (be == (4'b0001 << a))
        || (!a[0] && be == (4'b0011 << a))
        || (a == 2'd0 && be == 4'b1111);
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load extender: picks byte/half from a word and sign/zero extends.
// Ports: word, off (byte offset), op (load type) -> result.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  op,
  output logic [31:0] result
);

  logic [15:0] half;
  logic [7:0]  bsel;

  always_comb begin
    half   = off[1] ? word[31:16] : word[15:0];
    bsel   = word[{off, 3'b000} +: 8];
    result = '0;
    case (op)
      LD_W:    result = word;
      LD_H:    result = {{16{half[15]}}, half};
      LD_HU:   result = {16'h0000, half};
      LD_B:    result = {{24{bsel[7]}}, bsel};
      LD_BU:   result = {24'h000000, bsel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dm_bank.sv
// Byte-enabled data memory bank with post-reset zero sweep and
// 1-cycle extended loads. Ports: clk, reset, addr, wdata, byteen,
// rd_en, ld_op, hold -> busy, rdata, rd_valid, adr_err.
// Define DM_ALIGN_CHECK_EN for alignment/range error detection.
module dm_bank
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  input  logic        rd_en,
  input  logic [2:0]  ld_op,
  input  logic        hold,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        rd_valid,
  output logic        adr_err
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

  dm_state_e   state;
  logic [AW-1:0] cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic          ready;
  logic          in_range;
  logic [AW-1:0] widx;
  logic [31:0]   old_w;
  logic [31:0]   merged;
  logic          we;

  logic [31:0] rd_word;
  logic [1:0]  rd_off;
  logic [2:0]  rd_op;

  assign ready    = (state == READY);
  assign busy     = !ready;
  assign in_range = {2'b00, addr[31:2]} < 32'(DEPTH_WORDS);
  assign widx     = addr[AW+1:2];
  // Out-of-range reads see zero and never touch an aliased word.
  assign old_w    = in_range ? mem[widx] : '0;

`ifdef DM_ALIGN_CHECK_EN
  logic st_err;
  logic ld_err;

  assign st_err = (|byteen) && !be_legal(byteen, addr[1:0]);
  assign ld_err = rd_en && (
      (ld_op == LD_W && addr[1:0] != 2'd0)
   || ((ld_op == LD_H || ld_op == LD_HU) && addr[0]));
  assign adr_err = st_err || ld_err
                || ((|byteen || rd_en) && !in_range);
`else
  assign adr_err = 1'b0;
`endif

  assign we = ready && !hold && (|byteen)
           && !adr_err && in_range;

  // Same-edge read sees the bytes being written.
  always_comb begin
    merged = old_w;
    for (int i = 0; i < 4; i++) begin
      if (we && byteen[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      cnt      <= '0;
      rd_valid <= 1'b0;
      rd_word  <= '0;
      rd_off   <= 2'd0;
      rd_op    <= LD_W;
    end else if (!ready) begin
      rd_valid <= 1'b0;
      if (cnt == LAST) state <= READY;
      else             cnt   <= cnt + 1'b1;
    end else if (!hold) begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_word <= merged;
        rd_off  <= addr[1:0];
        rd_op   <= ld_op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!ready)  mem[cnt]  <= '0;
      else if (we) mem[widx] <= merged;
    end
  end

  dm_load_ext u_ext (
    .word   (rd_word),
    .off    (rd_off),
    .op     (rd_op),
    .result (rdata)
  );

endmodule

// File: tb/tb_dm_bank.sv
// Self-checking bench for dm_bank: byte-level reference model
// compared every cycle, plus directed literal expectations.
module tb_dm_bank;
  import dm_pkg::*;

  localparam int D = 3072;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  byteen = '0;
  logic        rd_en = 1'b0;
  logic [2:0]  ld_op = LD_W;
  logic        hold = 1'b0;
  logic        busy;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        adr_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dm_bank #(.DEPTH_WORDS(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .byteen   (byteen),
    .rd_en    (rd_en),
    .ld_op    (ld_op),
    .hold     (hold),
    .busy     (busy),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .adr_err  (adr_err)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mm [4*D];
  int          m_left = 0;
  bit          m_valid = 0;
  bit          m_started = 0;
  logic [31:0] m_rdata = '0;
  logic [31:0] mw;
  bit          moor;
  int          mbase;

  function automatic bit m_err(input logic [31:0] a32,
                               input logic [3:0] be,
                               input logic re,
                               input logic [2:0] op);
`ifdef DM_ALIGN_CHECK_EN
    int  a;
    bit  oor, serr, lerr;
    a    = int'(a32[1:0]);
    oor  = a32 >= 32'(4*D);
    serr = (be != 0) && !((int'(be) == (1 << a))
        || (a % 2 == 0 && int'(be) == (3 << a))
        || (a == 0 && be == 4'hF));
    lerr = re && ((op == LD_W && a != 0)
        || ((op == LD_H || op == LD_HU) && a % 2 == 1));
    return serr || lerr || ((be != 0 || re) && oor);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] w,
                                        input logic [1:0] off,
                                        input logic [2:0] op);
    logic [31:0] b, h;
    b = w >> (8 * int'(off));
    h = w >> (off[1] ? 16 : 0);
    case (op)
      LD_W:    return w;
      LD_H:    return {{16{h[15]}}, h[15:0]};
      LD_HU:   return {16'h0, h[15:0]};
      LD_B:    return {{24{b[7]}}, b[7:0]};
      LD_BU:   return {24'h0, b[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_started = 1;
      m_left    = D;
      m_valid   = 0;
      m_rdata   = 0;
      foreach (mm[i]) mm[i] = 8'h00;
    end else if (m_left > 0) begin
      m_left--;
      m_valid = 0;
    end else if (!hold) begin
      moor  = addr >= 32'(4*D);
      mbase = int'({addr[31:2], 2'b00});
      if (byteen != 0 && !m_err(addr, byteen, rd_en, ld_op)
          && !moor)
        for (int i = 0; i < 4; i++)
          if (byteen[i]) mm[mbase+i] = wdata[8*i +: 8];
      if (rd_en) begin
        mw = 0;
        if (!moor)
          for (int i = 0; i < 4; i++) mw[8*i +: 8] = mm[mbase+i];
        m_rdata = m_ext(mw, addr[1:0], ld_op);
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("rd_valid", 32'(rd_valid), 32'(m_valid));
      check("adr_err", 32'(adr_err),
            32'(m_err(addr, byteen, rd_en, ld_op)));
      if (m_valid) check("rdata", rdata, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    byteen = 4'h0;
    rd_en  = 1'b0;
    hold   = 1'b0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic re,
                       input logic [2:0] op, input logic h);
    addr = a; wdata = wd; byteen = be;
    rd_en = re; ld_op = op; hold = h;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
    drive(a, wd, be, 1'b0, LD_W, 1'b0);
    tick();
    idle();
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] op,
                      input string name, input logic [31:0] exp);
    drive(a, 32'h0, 4'h0, 1'b1, op, 1'b0);
    tick();
    idle();
    @(negedge clk);
    check({name, "_valid"}, 32'(rd_valid), 32'd1);
    check(name, rdata, exp);
    #1;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (n <= D + 5) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check(name, 32'(n), 32'(D));
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  logic [31:0] w10;

  initial begin
`ifdef DM_ALIGN_CHECK_EN
    w10 = 32'h80FF7F01;
`else
    w10 = 32'h80AB7F01;
`endif
    tick();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    #1;
    tick();
    reset = 1'b0;
    count_busy("sweep_len");

    load(32'h100, LD_W, "ld_w_100", 32'h0);

    store(32'h10, 32'h80FF7F01, 4'hF);
    load(32'h11, LD_B,  "lb_11",  32'h0000007F);
    load(32'h12, LD_B,  "lb_12",  32'hFFFFFFFF);
    load(32'h12, LD_BU, "lbu_12", 32'h000000FF);
    load(32'h12, LD_H,  "lh_12",  32'hFFFF80FF);
    load(32'h12, LD_HU, "lhu_12", 32'h000080FF);
    load(32'h10, LD_H,  "lh_10",  32'h00007F01);
    load(32'h13, LD_BU, "lbu_13", 32'h00000080);
    load(32'h10, 3'd7,  "ld_undef", 32'h0);

    drive(32'h10, 32'h00AB0000, 4'b0100, 1'b1, LD_W, 1'b0);
    tick();
    drive(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, LD_B, 1'b1);
    @(negedge clk);
    check("bypass", rdata, w10);
    #1;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("hold_valid", 32'(rd_valid), 32'd1);
      check("hold_rdata", rdata, w10);
      #1;
    end
    idle();
    load(32'h10, LD_W, "after_hold", w10);

`ifdef DM_ALIGN_CHECK_EN
    drive(32'h2, 32'h0, 4'h0, 1'b1, LD_W, 1'b0);
    @(negedge clk);
    check("err_lw_2", 32'(adr_err), 32'd1);
    #1;
    tick();
    idle();
    drive(32'h10, 32'hFFFFFFFF, 4'b0110, 1'b0, LD_W, 1'b0);
    @(negedge clk);
    check("err_be_0110", 32'(adr_err), 32'd1);
    #1;
    tick();
    idle();
    load(32'h10, LD_W, "no_wr_0110", w10);
    drive(32'h12, 32'h12340000, 4'b1100, 1'b0, LD_W, 1'b0);
    @(negedge clk);
    check("ok_sh_12", 32'(adr_err), 32'd0);
    #1;
    tick();
    idle();
    load(32'h10, LD_W, "sh_12", 32'h12347F01);
    drive(32'h3000, 32'h12345678, 4'hF, 1'b0, LD_W, 1'b0);
    @(negedge clk);
    check("err_oor", 32'(adr_err), 32'd1);
    #1;
    tick();
    idle();
`else
    store(32'h3000, 32'h12345678, 4'hF);
`endif
    store(32'h4000, 32'h55AA55AA, 4'hF);
    load(32'h3000, LD_W, "ld_oor", 32'h0);
    load(32'h0, LD_W, "no_alias", 32'h0);

    store(32'h2FFC, 32'hCAFEBABE, 4'hF);
    load(32'h2FFE, LD_HU, "lhu_top", 32'h0000CAFE);
    load(32'h2FFC, LD_B,  "lb_top",  32'hFFFFFFBE);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (100) tick();
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    #1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy("resweep_len");
    load(32'h2FFC, LD_W, "clr_top", 32'h0);
    load(32'h10, LD_W, "clr_10", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
